// File: rtl/jt5205_enc.sv
// rtl/jt5205_enc.sv - MSM5205-compatible 4-bit ADPCM encoder
// Mirrors the JT5205 decoder predictor/step state so every code decodes bit-exactly.
module jt5205_enc #(
    parameter logic signed [11:0] PRED_INIT = -12'sd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [11:0] pcm_in,
    input  logic        pcm_valid,
    output logic        pcm_ready,
    output logic [3:0]  code,
    output logic        code_valid,
    output logic [11:0] recon,
    output logic [5:0]  step_idx
);

    typedef enum logic [2:0] {S_IDLE, S_Q2, S_Q1, S_Q0, S_UPD} state_t;

    state_t      state_q, state_d;
    logic [12:0] mag_q, mag_d;
    logic [10:0] d_q, d_d;
    logic        sign_q, sign_d;
    logic [2:0]  bits_q, bits_d;
    logic [11:0] recon_q, recon_d;
    logic [5:0]  idx_q, idx_d;
    logic [3:0]  code_q, code_d;
    logic        code_valid_q, code_valid_d;

    logic [13:0] diff;
    logic [10:0] dsh;
    logic        ge;
    logic [12:0] qn;
    logic [13:0] rsum;
    logic signed [7:0] inc;
    logic signed [7:0] nidx;

    function automatic logic [10:0] step_lut(input logic [5:0] i);
        case (i)
            6'd0:  step_lut = 11'd16;   6'd1:  step_lut = 11'd17;   6'd2:  step_lut = 11'd19;
            6'd3:  step_lut = 11'd21;   6'd4:  step_lut = 11'd23;   6'd5:  step_lut = 11'd25;
            6'd6:  step_lut = 11'd28;   6'd7:  step_lut = 11'd31;   6'd8:  step_lut = 11'd34;
            6'd9:  step_lut = 11'd37;   6'd10: step_lut = 11'd41;   6'd11: step_lut = 11'd45;
            6'd12: step_lut = 11'd50;   6'd13: step_lut = 11'd55;   6'd14: step_lut = 11'd60;
            6'd15: step_lut = 11'd66;   6'd16: step_lut = 11'd73;   6'd17: step_lut = 11'd80;
            6'd18: step_lut = 11'd88;   6'd19: step_lut = 11'd97;   6'd20: step_lut = 11'd107;
            6'd21: step_lut = 11'd118;  6'd22: step_lut = 11'd130;  6'd23: step_lut = 11'd143;
            6'd24: step_lut = 11'd157;  6'd25: step_lut = 11'd173;  6'd26: step_lut = 11'd190;
            6'd27: step_lut = 11'd209;  6'd28: step_lut = 11'd230;  6'd29: step_lut = 11'd253;
            6'd30: step_lut = 11'd279;  6'd31: step_lut = 11'd307;  6'd32: step_lut = 11'd337;
            6'd33: step_lut = 11'd371;  6'd34: step_lut = 11'd408;  6'd35: step_lut = 11'd449;
            6'd36: step_lut = 11'd494;  6'd37: step_lut = 11'd544;  6'd38: step_lut = 11'd598;
            6'd39: step_lut = 11'd658;  6'd40: step_lut = 11'd724;  6'd41: step_lut = 11'd796;
            6'd42: step_lut = 11'd876;  6'd43: step_lut = 11'd963;  6'd44: step_lut = 11'd1060;
            6'd45: step_lut = 11'd1166; 6'd46: step_lut = 11'd1282; 6'd47: step_lut = 11'd1411;
            default: step_lut = 11'd1552;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        mag_d        = mag_q;
        d_d          = d_q;
        sign_d       = sign_q;
        bits_d       = bits_q;
        recon_d      = recon_q;
        idx_d        = idx_q;
        code_d       = code_q;
        code_valid_d = 1'b0;

        diff = {{2{pcm_in[11]}}, pcm_in} - {{2{recon_q[11]}}, recon_q};

        // Successive approximation uses d, d/2, d/4 with truncation, like the decoder
        case (state_q)
            S_Q1:    dsh = d_q >> 1;
            S_Q0:    dsh = d_q >> 2;
            default: dsh = d_q;
        endcase
        ge = (mag_q >= {2'b00, dsh});

        qn = {5'b0, d_q[10:3]}
           + (bits_q[2] ? {2'b00, d_q}      : 13'd0)
           + (bits_q[1] ? {3'b000, d_q[10:1]} : 13'd0)
           + (bits_q[0] ? {4'b0000, d_q[10:2]} : 13'd0);
        rsum = sign_q ? ({{2{recon_q[11]}}, recon_q} - {1'b0, qn})
                      : ({{2{recon_q[11]}}, recon_q} + {1'b0, qn});

        if (bits_q[2]) begin
            case (bits_q[1:0])
                2'd0:    inc = 8'sd2;
                2'd1:    inc = 8'sd4;
                2'd2:    inc = 8'sd6;
                default: inc = 8'sd8;
            endcase
        end else begin
            inc = -8'sd1;
        end
        nidx = $signed({2'b00, idx_q}) + inc;

        case (state_q)
            S_IDLE: if (pcm_valid && cen) begin
                sign_d  = diff[13];
                mag_d   = diff[13] ? (~diff[12:0] + 13'd1) : diff[12:0];
                d_d     = step_lut(idx_q);
                bits_d  = 3'b000;
                state_d = S_Q2;
            end
            S_Q2: if (cen) begin
                bits_d[2] = ge;
                if (ge) mag_d = mag_q - {2'b00, dsh};
                state_d = S_Q1;
            end
            S_Q1: if (cen) begin
                bits_d[1] = ge;
                if (ge) mag_d = mag_q - {2'b00, dsh};
                state_d = S_Q0;
            end
            S_Q0: if (cen) begin
                bits_d[0] = ge;
                if (ge) mag_d = mag_q - {2'b00, dsh};
                state_d = S_UPD;
            end
            S_UPD: if (cen) begin
                if ($signed(rsum) > 14'sd2047)       recon_d = 12'h7FF;
                else if ($signed(rsum) < -14'sd2048) recon_d = 12'h800;
                else                                  recon_d = rsum[11:0];
                if (nidx < 8'sd0)       idx_d = 6'd0;
                else if (nidx > 8'sd48) idx_d = 6'd48;
                else                    idx_d = nidx[5:0];
                code_d       = {sign_q, bits_q};
                code_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mag_q        <= 13'd0;
            d_q          <= 11'd0;
            sign_q       <= 1'b0;
            bits_q       <= 3'b000;
            recon_q      <= PRED_INIT;
            idx_q        <= 6'd0;
            code_q       <= 4'd0;
            code_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mag_q        <= mag_d;
            d_q          <= d_d;
            sign_q       <= sign_d;
            bits_q       <= bits_d;
            recon_q      <= recon_d;
            idx_q        <= idx_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
        end
    end

    assign pcm_ready  = (state_q == S_IDLE);
    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign recon      = recon_q;
    assign step_idx   = idx_q;

endmodule
